// File: rtl/dpwm_pkg.sv
// Shared types, default sizes and helpers for the DPWM controller slice.
package dpwm_pkg;

    localparam int unsigned CW_DEFAULT  = 6;
    localparam int unsigned W_DEFAULT   = CW_DEFAULT + 2;
    localparam int unsigned MAX_DEFAULT = (32'd1 << W_DEFAULT) - 32'd1;
    localparam int unsigned DT_DEFAULT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Total period counter width for a given coarse width (coarse + 2 fine bits).
    function automatic int unsigned cnt_width(input int unsigned cw);
        return cw + 32'd2;
    endfunction

    // Terminal count of the period counter for a given coarse width.
    function automatic int unsigned cnt_max(input int unsigned cw);
        return (32'd1 << (cw + 32'd2)) - 32'd1;
    endfunction

    // Complementary-output window: opens DT cycles after the main pulse ends and
    // closes DT cycles before the period wraps. Evaluated in 32 bits so that
    // active+dt can never wrap back into range.
    function automatic logic dead_time_on(input int unsigned cnt,
                                          input int unsigned active,
                                          input int unsigned dt,
                                          input int unsigned max_cnt);
        return (cnt >= active + dt) && (cnt <= max_cnt - dt);
    endfunction

endpackage

// File: rtl/dpwm_if.sv
// Duty-command handshake between the compensator (master) and the DPWM (slave).
interface dpwm_if
    import dpwm_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);

    logic [W-1:0] duty_in;
    logic         duty_valid;
    logic         duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/dpwm_period_cnt.sv
// Period counter built from a CW-bit coarse stage and a 2-bit fine phase.
module dpwm_period_cnt
    import dpwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW+1:0] cnt,
    output logic          wrap,
    output logic [1:0]    phase
);

    logic [CW-1:0] coarse_q, coarse_d;
    logic [1:0]    fine_q, fine_d;

    // Next count: clear wins over increment; coarse advances on fine carry.
    always_comb begin
        coarse_d = coarse_q;
        fine_d   = fine_q;
        if (clr) begin
            coarse_d = '0;
            fine_d   = '0;
        end else if (inc) begin
            fine_d = fine_q + 2'd1;
            if (fine_q == 2'b11) begin
                coarse_d = coarse_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            coarse_q <= '0;
            fine_q   <= '0;
        end else begin
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
        end
    end

    assign cnt   = {coarse_q, fine_q};
    assign wrap  = &{coarse_q, fine_q};
    assign phase = fine_q;

endmodule

// File: rtl/dpwm_ctrl.sv
// Counter-based DPWM: double-buffered duty, complementary outputs with dead time,
// start/stop sequencing through IDLE, RUN and DRAIN.
module dpwm_ctrl
    import dpwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT,
    parameter int unsigned DT = DT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    dpwm_if.slave      duty,
    output logic       pwm_out,
    output logic       pwm_n,
    output logic       period_start,
    output logic [1:0] phase,
    output logic       busy
);

    localparam int unsigned W    = cnt_width(CW);
    localparam int unsigned MAX  = cnt_max(CW);
    localparam int unsigned DMAX = MAX - 32'd3;
    localparam logic [W-1:0] DMAX_V = W'(DMAX);

    state_e       state_q, state_d;
    logic [W-1:0] active_q, active_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic         shadow_full_q, shadow_full_d;
    logic         pwm_out_q, pwm_out_d;
    logic         pwm_n_q, pwm_n_d;
    logic         period_start_q, period_start_d;

    logic [W-1:0] cnt;
    logic         wrap;
    logic         cnt_inc;
    logic         cnt_clr;
    logic         accept;
    logic         load_active;
    logic         busy_next;
    logic [W-1:0] duty_clamped;

    dpwm_period_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .wrap  (wrap),
        .phase (phase)
    );

    assign duty.duty_ready = !shadow_full_q;
    assign accept          = duty.duty_valid && !shadow_full_q;
    assign duty_clamped    = (duty.duty_in > DMAX_V) ? DMAX_V : duty.duty_in;

    // The counter sits at zero in IDLE and free-runs otherwise; a drain that
    // ends at MAX wraps to zero on its own, so no extra clear is needed there.
    assign cnt_clr = (state_q == IDLE);
    assign cnt_inc = (state_q != IDLE);

    // Next-state logic for run/stop sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow/active double buffer. A wrap in DRAIN with en already back high
    // continues as a RUN period boundary, so the pending command is taken there too.
    always_comb begin
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        load_active   = ((state_q == IDLE) && en) ||
                        (wrap && ((state_q == RUN) || ((state_q == DRAIN) && en)));
        if (load_active && shadow_full_q) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (accept) begin
            shadow_d      = duty_clamped;
            shadow_full_d = 1'b1;
        end
    end

    // Output decode from the current count; registered one cycle later.
    always_comb begin
        busy_next      = (state_d != IDLE);
        pwm_out_d      = busy_next && (cnt < active_q);
        pwm_n_d        = busy_next &&
                         dead_time_on(32'(cnt), 32'(active_q), DT, MAX);
        period_start_d = (state_q == RUN) && (cnt == '0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Duty buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q       <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            pwm_out_q      <= 1'b0;
            pwm_n_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            pwm_out_q      <= pwm_out_d;
            pwm_n_q        <= pwm_n_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign pwm_n        = pwm_n_q;
    assign period_start = period_start_q;
    assign busy         = (state_q != IDLE);

endmodule
